// File: rtl/nvme_qpair_engine.sv
// rtl/nvme_qpair_engine.sv - NVMe I/O queue-pair engine: builds SQEs, polls CQEs by phase tag, rings doorbells
module nvme_qpair_engine #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned QID      = 1,
  parameter int unsigned DSTRD    = 0,
  parameter int unsigned NSID     = 1,
  parameter logic [31:0] SQ_BASE  = 32'h0002_0000,
  parameter logic [31:0] CQ_BASE  = 32'h0002_0400,
  parameter logic [31:0] BUF_BASE = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [63:0]              cmd_lba,
  input  logic [15:0]              cmd_nlb,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [15:0]              cpl_cid,
  output logic [14:0]              cpl_status,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     sq_awvalid,
  input  logic                     sq_awready,
  output logic [31:0]              sq_awaddr,
  output logic                     sq_wvalid,
  input  logic                     sq_wready,
  output logic [511:0]             sq_wdata,
  input  logic                     sq_bvalid,
  output logic                     sq_bready,
  output logic                     db_awvalid,
  input  logic                     db_awready,
  output logic [31:0]              db_awaddr,
  output logic                     db_wvalid,
  input  logic                     db_wready,
  output logic [31:0]              db_wdata,
  input  logic                     db_bvalid,
  output logic                     db_bready,
  output logic                     cq_arvalid,
  input  logic                     cq_arready,
  output logic [31:0]              cq_araddr,
  input  logic                     cq_rvalid,
  output logic                     cq_rready,
  input  logic [127:0]             cq_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = PW + 1;
  localparam logic [31:0] DB_SQ_ADDR = 32'h1000 + 32'((2 * QID) * (4 << DSTRD));
  localparam logic [31:0] DB_CQ_ADDR = 32'h1000 + 32'((2 * QID + 1) * (4 << DSTRD));

  typedef enum logic [2:0] {
    IDLE, SQ_AW_W, SQ_B, SQDB, CQ_AR, CQ_R, CPL, CQDB
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_sq_tail;
  logic [PW-1:0]   r_cq_head;
  logic [IW-1:0]   r_inflight;
  logic            r_phase;
  logic            r_rr;
  logic            r_write;
  logic [63:0]     r_lba;
  logic [15:0]     r_nlb;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_db_b;
  logic [15:0]     r_cpl_cid;
  logic [14:0]     r_cpl_status;

  logic            w_can_issue;
  logic            w_can_poll;
  logic            w_pick_issue;
  logic            w_pick_poll;
  logic            w_aw_done_n;
  logic            w_w_done_n;
  logic [511:0]    w_entry;
  logic            w_unused;

  // Low CQE dwords (command-specific, SQ head/ID) are not needed by this engine.
  assign w_unused = ^cq_rdata[95:0];

  // One slot is kept empty, so issue stops at DEPTH-1 outstanding.
  assign w_can_issue  = cmd_valid & (r_inflight < IW'(DEPTH - 1));
  assign w_can_poll   = (r_inflight != '0);
  assign w_pick_issue = w_can_issue & (~w_can_poll | ~r_rr);
  assign w_pick_poll  = w_can_poll & (~w_can_issue | r_rr);

  // Address/data handshakes complete independently; remember which one is done.
  assign w_aw_done_n = r_aw_done | (sq_awvalid & sq_awready) | (db_awvalid & db_awready);
  assign w_w_done_n  = r_w_done | (sq_wvalid & sq_wready) | (db_wvalid & db_wready);

  // Submission queue entry assembled from the latched command and the current tail slot.
  always_comb begin
    w_entry          = '0;
    w_entry[7:0]     = r_write ? 8'h01 : 8'h02;
    w_entry[31:16]   = 16'(r_sq_tail);
    w_entry[63:32]   = 32'(NSID);
    w_entry[255:192] = {32'h0, BUF_BASE + (32'(r_sq_tail) << 12)};
    w_entry[383:320] = r_lba;
    w_entry[399:384] = r_nlb;
  end

  // Next-state and handshake outputs; address/data outputs read 0 outside their state.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    sq_awvalid = 1'b0;
    sq_wvalid  = 1'b0;
    sq_bready  = 1'b0;
    db_awvalid = 1'b0;
    db_wvalid  = 1'b0;
    db_bready  = 1'b0;
    cq_arvalid = 1'b0;
    cq_rready  = 1'b0;
    cpl_valid  = 1'b0;
    sq_awaddr  = '0;
    sq_wdata   = '0;
    db_awaddr  = '0;
    db_wdata   = '0;
    cq_araddr  = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_issue) begin
          cmd_ready = ~rst;
          w_next    = SQ_AW_W;
        end else if (w_pick_poll) begin
          w_next = CQ_AR;
        end
      end
      SQ_AW_W: begin
        sq_awvalid = ~r_aw_done;
        sq_wvalid  = ~r_w_done;
        sq_awaddr  = SQ_BASE + (32'(r_sq_tail) << 6);
        sq_wdata   = w_entry;
        if ((r_aw_done | sq_awready) & (r_w_done | sq_wready)) w_next = SQ_B;
      end
      SQ_B: begin
        sq_bready = 1'b1;
        if (sq_bvalid) w_next = SQDB;
      end
      SQDB, CQDB: begin
        db_awaddr = (r_state == SQDB) ? DB_SQ_ADDR : DB_CQ_ADDR;
        db_wdata  = (r_state == SQDB) ? 32'(r_sq_tail) : 32'(r_cq_head);
        if (!r_db_b) begin
          db_awvalid = ~r_aw_done;
          db_wvalid  = ~r_w_done;
        end else begin
          db_bready = 1'b1;
          if (db_bvalid) w_next = IDLE;
        end
      end
      CQ_AR: begin
        cq_arvalid = 1'b1;
        cq_araddr  = CQ_BASE + (32'(r_cq_head) << 4);
        if (cq_arready) w_next = CQ_R;
      end
      CQ_R: begin
        cq_rready = 1'b1;
        if (cq_rvalid) w_next = (cq_rdata[112] == r_phase) ? CPL : IDLE;
      end
      CPL: begin
        cpl_valid = 1'b1;
        if (cpl_ready) w_next = CQDB;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, pointers, phase and latched command/completion fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sq_tail    <= '0;
      r_cq_head    <= '0;
      r_inflight   <= '0;
      r_phase      <= 1'b1;
      r_rr         <= 1'b0;
      r_write      <= 1'b0;
      r_lba        <= '0;
      r_nlb        <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_db_b       <= 1'b0;
      r_cpl_cid    <= '0;
      r_cpl_status <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_can_issue & w_can_poll) r_rr <= ~r_rr;
          if (cmd_ready) begin
            r_write <= cmd_write;
            r_lba   <= cmd_lba;
            r_nlb   <= cmd_nlb;
          end
        end
        SQ_AW_W: begin
          if (w_next != SQ_AW_W) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_done_n;
            r_w_done  <= w_w_done_n;
          end
        end
        SQ_B: begin
          if (sq_bvalid) begin
            r_sq_tail  <= r_sq_tail + PW'(1);
            r_inflight <= r_inflight + IW'(1);
          end
        end
        SQDB, CQDB: begin
          if (!r_db_b) begin
            if (w_aw_done_n & w_w_done_n) begin
              r_db_b    <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_aw_done <= w_aw_done_n;
              r_w_done  <= w_w_done_n;
            end
          end else if (db_bvalid) begin
            r_db_b <= 1'b0;
          end
        end
        CQ_R: begin
          if (cq_rvalid && (cq_rdata[112] == r_phase)) begin
            r_cpl_cid    <= cq_rdata[111:96];
            r_cpl_status <= cq_rdata[127:113];
          end
        end
        CPL: begin
          if (cpl_ready) begin
            r_cq_head  <= r_cq_head + PW'(1);
            r_inflight <= r_inflight - IW'(1);
            if (r_cq_head == PW'(DEPTH - 1)) r_phase <= ~r_phase;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpl_cid    = r_cpl_cid;
  assign cpl_status = r_cpl_status;
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_nvme_qpair_engine.sv
// tb/tb_nvme_qpair_engine.sv - scoreboard bench for nvme_qpair_engine with randomized fabric and device model
module tb_nvme_qpair_engine;

  localparam int DEPTH = 16;
  localparam int QID   = 3;
  localparam int DSTRD = 2;
  localparam int NSID  = 1;
  localparam logic [31:0] SQ_BASE  = 32'h0002_0000;
  localparam logic [31:0] CQ_BASE  = 32'h0002_0400;
  localparam logic [31:0] BUF_BASE = 32'h0008_0000;
  localparam logic [31:0] SQDB_A   = 32'h1060;
  localparam logic [31:0] CQDB_A   = 32'h1070;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_lba;
  logic [15:0] cmd_nlb;
  logic cpl_valid, cpl_ready;
  logic [15:0] cpl_cid;
  logic [14:0] cpl_status;
  logic [4:0] inflight;
  logic sq_awvalid, sq_awready, sq_wvalid, sq_wready, sq_bvalid, sq_bready;
  logic [31:0] sq_awaddr;
  logic [511:0] sq_wdata;
  logic db_awvalid, db_awready, db_wvalid, db_wready, db_bvalid, db_bready;
  logic [31:0] db_awaddr, db_wdata;
  logic cq_arvalid, cq_arready, cq_rvalid, cq_rready;
  logic [31:0] cq_araddr;
  logic [127:0] cq_rdata;

  nvme_qpair_engine #(
    .DEPTH(DEPTH), .QID(QID), .DSTRD(DSTRD), .NSID(NSID),
    .SQ_BASE(SQ_BASE), .CQ_BASE(CQ_BASE), .BUF_BASE(BUF_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_lba(cmd_lba), .cmd_nlb(cmd_nlb),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid), .cpl_status(cpl_status),
    .inflight(inflight),
    .sq_awvalid(sq_awvalid), .sq_awready(sq_awready), .sq_awaddr(sq_awaddr),
    .sq_wvalid(sq_wvalid), .sq_wready(sq_wready), .sq_wdata(sq_wdata),
    .sq_bvalid(sq_bvalid), .sq_bready(sq_bready),
    .db_awvalid(db_awvalid), .db_awready(db_awready), .db_awaddr(db_awaddr),
    .db_wvalid(db_wvalid), .db_wready(db_wready), .db_wdata(db_wdata),
    .db_bvalid(db_bvalid), .db_bready(db_bready),
    .cq_arvalid(cq_arvalid), .cq_arready(cq_arready), .cq_araddr(cq_araddr),
    .cq_rvalid(cq_rvalid), .cq_rready(cq_rready), .cq_rdata(cq_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event or timeout", name);
  endtask

  // Expected SQ entry built directly from the NVMe field layout.
  function automatic logic [511:0] exp_entry(input int k, input logic wr, input logic [63:0] lba,
                                             input logic [15:0] nlb);
    logic [511:0] e;
    int slot;
    slot = k % DEPTH;
    e = '0;
    e[31:0]    = {16'(slot), 2'b00, 4'b0000, 2'b00, (wr ? 8'h01 : 8'h02)};
    e[63:32]   = 32'(NSID);
    e[192 +: 64] = {32'h0, BUF_BASE + 32'(slot * 4096)};
    e[320 +: 64] = lba;
    e[384 +: 16] = nlb;
    return e;
  endfunction

  // Scoreboard queues and reference model state
  logic [31:0]  q_sq_addr[$];
  logic [511:0] q_sq_data[$];
  logic [31:0]  q_db_addr[$];
  logic [31:0]  q_db_data[$];
  logic [15:0]  q_cpl_cid[$];
  logic [14:0]  q_cpl_st[$];
  int m_acc = 0, m_cpl = 0, m_inflight = 0, m_sqdb = 0;
  bit m_sq_aw = 0, m_sq_w = 0, m_db_aw = 0, m_db_w = 0;

  // Fabric/device responder state
  logic [127:0] cq_mem[DEPTH];
  int d_posted = 0;
  bit post_en = 0, hold_sq = 0;
  bit sq_awg = 0, sq_wg = 0, sq_bp = 0, db_awg = 0, db_wg = 0, db_bp = 0, r_p = 0;
  int sq_bd = 0, db_bd = 0, r_d = 0, r_slot = 0;
  logic [127:0] r_data = '0;

  // Fabric and device: drive on negedge, observe handshakes just before posedge.
  initial begin
    sq_awready = 0; sq_wready = 0; sq_bvalid = 0;
    db_awready = 0; db_wready = 0; db_bvalid = 0;
    cq_arready = 0; cq_rvalid = 0; cq_rdata = '0; cpl_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) cq_mem[i] = '0;
        d_posted = 0;
        sq_awg = 0; sq_wg = 0; sq_bp = 0; db_awg = 0; db_wg = 0; db_bp = 0; r_p = 0;
        sq_bvalid = 0; db_bvalid = 0; cq_rvalid = 0; cq_rdata = '0;
      end else begin
        sq_awready = !hold_sq && ($urandom_range(0, 3) != 0);
        sq_wready  = !hold_sq && ($urandom_range(0, 3) != 0);
        sq_bvalid  = sq_bp && (sq_bd == 0);
        if (sq_bp && sq_bd > 0) sq_bd--;
        db_awready = ($urandom_range(0, 2) != 0);
        db_wready  = ($urandom_range(0, 2) != 0);
        db_bvalid  = db_bp && (db_bd == 0);
        if (db_bp && db_bd > 0) db_bd--;
        cq_arready = ($urandom_range(0, 2) != 0);
        cq_rvalid  = r_p && (r_d == 0);
        cq_rdata   = cq_rvalid ? r_data : '0;
        if (r_p && r_d > 0) r_d--;
        cpl_ready  = ($urandom_range(0, 2) != 0);
        if (post_en && d_posted < m_sqdb && $urandom_range(0, 3) == 0) begin
          logic [15:0] cid;
          logic [14:0] st;
          logic ph;
          cid = 16'($urandom);
          st  = 15'($urandom);
          ph  = ((d_posted / DEPTH) % 2) == 0;
          cq_mem[d_posted % DEPTH] = {st, ph, cid, 32'($urandom), 32'($urandom), 32'($urandom)};
          q_cpl_cid.push_back(cid);
          q_cpl_st.push_back(st);
          d_posted++;
        end
      end
      #3;
      if (!rst) begin
        if (sq_awvalid && sq_awready) sq_awg = 1;
        if (sq_wvalid && sq_wready) sq_wg = 1;
        if (sq_awg && sq_wg) begin sq_bp = 1; sq_bd = $urandom_range(0, 3); sq_awg = 0; sq_wg = 0; end
        if (sq_bvalid && sq_bready) sq_bp = 0;
        if (db_awvalid && db_awready) db_awg = 1;
        if (db_wvalid && db_wready) db_wg = 1;
        if (db_awg && db_wg) begin db_bp = 1; db_bd = $urandom_range(0, 3); db_awg = 0; db_wg = 0; end
        if (db_bvalid && db_bready) db_bp = 0;
        if (cq_arvalid && cq_arready) begin
          r_p = 1;
          r_d = $urandom_range(0, 3);
          r_slot = int'(((cq_araddr - CQ_BASE) >> 4) & 32'(DEPTH - 1));
          r_data = cq_mem[r_slot];
        end
        if (cq_rvalid && cq_rready) r_p = 0;
      end
    end
  end

  // Monitor: compares DUT traffic with the scoreboard and advances the model.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      q_sq_addr.delete(); q_sq_data.delete(); q_db_addr.delete(); q_db_data.delete();
      q_cpl_cid.delete(); q_cpl_st.delete();
      m_acc = 0; m_cpl = 0; m_inflight = 0; m_sqdb = 0;
      m_sq_aw = 0; m_sq_w = 0; m_db_aw = 0; m_db_w = 0;
    end else begin
      chk("inflight", 512'(inflight), 512'(m_inflight));
      if (cmd_ready) chk("full_guard", 512'(m_inflight < DEPTH - 1), 512'(1));
      if (cq_arvalid) chk("empty_guard", 512'(m_inflight != 0), 512'(1));
      if (cmd_valid && cmd_ready) begin
        q_sq_addr.push_back(SQ_BASE + 32'((m_acc % DEPTH) * 64));
        q_sq_data.push_back(exp_entry(m_acc, cmd_write, cmd_lba, cmd_nlb));
        q_db_addr.push_back(SQDB_A);
        q_db_data.push_back(32'((m_acc + 1) % DEPTH));
        m_acc++;
      end
      if (sq_awvalid && sq_awready) begin
        if (q_sq_addr.size() == 0) fail_now("sq_aw_unexpected");
        else chk("sq_awaddr", 512'(sq_awaddr), 512'(q_sq_addr[0]));
        m_sq_aw = 1;
      end
      if (sq_wvalid && sq_wready) begin
        if (q_sq_data.size() == 0) fail_now("sq_w_unexpected");
        else chk("sq_wdata", sq_wdata, q_sq_data[0]);
        m_sq_w = 1;
      end
      if (m_sq_aw && m_sq_w) begin
        if (q_sq_addr.size() != 0) begin void'(q_sq_addr.pop_front()); void'(q_sq_data.pop_front()); end
        m_sq_aw = 0; m_sq_w = 0;
      end
      if (sq_bvalid && sq_bready) m_inflight++;
      if (db_awvalid && db_awready) begin
        if (q_db_addr.size() == 0) fail_now("db_aw_unexpected");
        else chk("db_awaddr", 512'(db_awaddr), 512'(q_db_addr[0]));
        m_db_aw = 1;
      end
      if (db_wvalid && db_wready) begin
        if (q_db_data.size() == 0) fail_now("db_w_unexpected");
        else chk("db_wdata", 512'(db_wdata), 512'(q_db_data[0]));
        m_db_w = 1;
      end
      if (m_db_aw && m_db_w) begin
        if (q_db_addr.size() != 0) begin
          if (q_db_addr[0] == SQDB_A) m_sqdb++;
          void'(q_db_addr.pop_front()); void'(q_db_data.pop_front());
        end
        m_db_aw = 0; m_db_w = 0;
      end
      if (cq_arvalid && cq_arready)
        chk("cq_araddr", 512'(cq_araddr), 512'(CQ_BASE + 32'((m_cpl % DEPTH) * 16)));
      if (cpl_valid && cpl_ready) begin
        if (q_cpl_cid.size() == 0) fail_now("cpl_unexpected");
        else begin
          chk("cpl_cid", 512'(cpl_cid), 512'(q_cpl_cid.pop_front()));
          chk("cpl_status", 512'(cpl_status), 512'(q_cpl_st.pop_front()));
        end
        m_cpl++;
        m_inflight--;
        q_db_addr.push_back(CQDB_A);
        q_db_data.push_back(32'(m_cpl % DEPTH));
      end
    end
  end

  task automatic issue_n(input int n, input int gap_max, input bit directed);
    int got = 0;
    int budget = 200 * n + 1000;
    bit acc = 0;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (acc) begin cmd_valid = 0; acc = 0; end
      if (!cmd_valid && $urandom_range(0, gap_max) == 0) begin
        cmd_valid = 1;
        if (directed && got == 0) begin
          cmd_write = 1; cmd_lba = 64'd5; cmd_nlb = 16'd0;
        end else begin
          cmd_write = 1'($urandom);
          cmd_lba   = {$urandom, $urandom};
          cmd_nlb   = 16'($urandom);
        end
      end
      #3;
      if (cmd_valid && cmd_ready) begin got++; acc = 1; end
    end
    @(negedge clk);
    cmd_valid = 0;
    if (got < n) fail_now("issue_timeout");
  endtask

  task automatic wait_drain(input string name);
    int budget = 20000;
    while (budget > 0 && !(m_cpl == m_acc && m_inflight == 0 &&
                           q_db_addr.size() == 0 && q_cpl_cid.size() == 0)) begin
      @(negedge clk);
      budget--;
    end
    chk(name, 512'(budget > 0), 512'(1));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_lba = '0; cmd_nlb = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_ready", 512'(cmd_ready), 512'(0));
    chk("rst_sq_awvalid", 512'(sq_awvalid), 512'(0));
    chk("rst_db_awvalid", 512'(db_awvalid), 512'(0));
    chk("rst_cq_arvalid", 512'(cq_arvalid), 512'(0));
    chk("rst_cpl_valid", 512'(cpl_valid), 512'(0));
    chk("rst_inflight", 512'(inflight), 512'(0));
    chk("rst_sq_awaddr", 512'(sq_awaddr), 512'(0));
    chk("rst_cq_araddr", 512'(cq_araddr), 512'(0));
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);

    // Fill to DEPTH-1 with no completions posted; polls only see stale entries.
    issue_n(DEPTH - 1, 0, 1);
    repeat (300) begin
      @(negedge clk);
      cmd_valid = 1;
    end
    @(negedge clk);
    cmd_valid = 0;
    #4;
    chk("full_hold_accepts", 512'(m_acc), 512'(DEPTH - 1));
    chk("full_inflight", 512'(inflight), 512'(DEPTH - 1));
    post_en = 1;
    wait_drain("drain_full");

    // Randomized traffic spanning several CQ phase wraps.
    issue_n(50, 3, 0);
    wait_drain("drain_random");

    // Reset while the SQ entry write is stalled.
    hold_sq = 1;
    repeat (2) @(negedge clk);
    issue_n(1, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    chk("stall_sq_awvalid", 512'(sq_awvalid), 512'(1));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #2;
    chk("rstmid_sq_awvalid", 512'(sq_awvalid), 512'(0));
    chk("rstmid_sq_wvalid", 512'(sq_wvalid), 512'(0));
    chk("rstmid_db_valid", 512'(db_awvalid | db_wvalid), 512'(0));
    chk("rstmid_cq_arvalid", 512'(cq_arvalid), 512'(0));
    chk("rstmid_cpl_valid", 512'(cpl_valid), 512'(0));
    chk("rstmid_inflight", 512'(inflight), 512'(0));
    @(negedge clk);
    hold_sq = 0;
    rst = 0;
    issue_n(3, 1, 0);
    wait_drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nvme_qpair_engine.md
Name: nvme_qpair_engine

Overview:
- Parametrised successor to the single-queue NVMe write driver. Owns one I/O submission/completion queue pair of configurable depth and queue ID.
- Builds READ or WRITE SQ entries and rings the SQ tail doorbell.
- Polls CQ memory using the phase tag, returns completions upstream, and rings the CQ head doorbell.
- Sits between the host command front-end and the AXI fabric that reaches queue memory and NVMe BAR0.

Parameters:
- DEPTH, 16, entries per SQ and per CQ; power of two, 2..256.
- QID, 1, I/O queue ID; selects the doorbell offset.
- DSTRD, 0, CAP.DSTRD doorbell stride.
- NSID, 1, namespace ID placed in CDW1.
- SQ_BASE, 32'h0002_0000, SQ byte base; 64 B per entry.
- CQ_BASE, 32'h0002_0400, CQ byte base; 16 B per entry.
- BUF_BASE, 32'h0, data buffer base; one 4 KB slot per SQ index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1 = WRITE (opcode 01h), 0 = READ (opcode 02h)
- cmd_lba  in  64  starting LBA
- cmd_nlb  in  16  0-based block count
- cpl_valid  out  1  completion available
- cpl_ready  in  1  completion consumed
- cpl_cid  out  16  completed command ID
- cpl_status  out  15  CQE status field
- inflight  out  $clog2(DEPTH)+1  commands outstanding
- sq_awvalid/sq_awready/sq_awaddr[31:0]  out/in/out  SQ entry write address
- sq_wvalid/sq_wready/sq_wdata[511:0]  out/in/out  SQ entry data; wstrb all-ones, single beat
- sq_bvalid/sq_bready  in/out  SQ write response
- db_awvalid/db_awready/db_awaddr[31:0]  out/in/out  doorbell write address
- db_wvalid/db_wready/db_wdata[31:0]  out/in/out  doorbell data
- db_bvalid/db_bready  in/out  doorbell write response
- cq_arvalid/cq_arready/cq_araddr[31:0]  out/in/out  CQE read address
- cq_rvalid/cq_rready/cq_rdata[127:0]  in/out/in  CQE read data

Behaviour:
- Reset values:
  - State IDLE; sq_tail = 0, cq_head = 0, inflight = 0, phase = 1, rr = 0.
  - All valid/ready outputs 0; data/address outputs 0.
  - rst mid-transaction abandons the transaction; no completion is emitted.
- State machine: IDLE, SQ_AW_W, SQ_B, SQDB, CQ_AR, CQ_R, CPL, CQDB.
  - The shared doorbell sequence (DB_SEND -> DB_B) is embedded in SQDB and CQDB.
- Arbitration in IDLE:
  - can_issue = cmd_valid & (inflight < DEPTH-1).
  - can_poll = inflight != 0.
  - When both are true, the round-robin bit rr chooses the path and then toggles.
  - cmd_ready pulses for 1 cycle on the IDLE->SQ_AW_W transition only.
  - cmd_write, cmd_lba and cmd_nlb are latched on that pulse.
- SQ_AW_W:
  - sq_awaddr = SQ_BASE + sq_tail*64.
  - awvalid and wvalid are raised together; each drops independently once its handshake completes.
  - Exit when both have completed, in any order or the same cycle.
- SQ entry fields:
  - CDW0 = {cid = zero-extended sq_tail, PSDT 00, 0000, fuse 00, opcode}.
  - CDW1 = NSID; CDW2-9 = 0 except PRP1 [192+:64] = BUF_BASE + sq_tail*4096.
  - CDW10-11 = cmd_lba; CDW12[15:0] = cmd_nlb; CDW13-15 = 0.
- SQ_B: sq_bready = 1; on bvalid, sq_tail <= (sq_tail+1) mod DEPTH and inflight += 1. A nonzero bresp is still counted.
- SQDB:
  - db_awaddr = 32'h1000 + (2*QID)*(4<<DSTRD); db_wdata = new sq_tail.
  - aw and w are handshaken independently, then db_bready = 1 until bvalid, then IDLE.
- CQ_AR: cq_araddr = CQ_BASE + cq_head*16; hold until arready.
- CQ_R:
  - cq_rready = 1. On rvalid, capture rdata[127:96].
  - If bit[112] (P) != phase: no new entry; go to IDLE (re-poll later).
  - Otherwise go to CPL with cpl_cid = rdata[111:96] and cpl_status = rdata[127:113].
- CPL:
  - cpl_valid is held, with stable data, until cpl_ready.
  - Then cq_head <= (cq_head+1) mod DEPTH; phase toggles when cq_head wraps DEPTH-1 -> 0; inflight -= 1.
- CQDB: db_awaddr = 32'h1000 + (2*QID+1)*(4<<DSTRD), db_wdata = new cq_head; same doorbell sequence as SQDB, then IDLE.
- Full and empty:
  - Full is declared at DEPTH-1 outstanding (one slot kept empty); cmd_ready then stays 0.
  - With 0 outstanding, no CQ reads are issued.
- Pointer arithmetic: modulo DEPTH, width $clog2(DEPTH); inflight never underflows or overflows.

Test Plan:
- Single WRITE (cmd_lba = 5, nlb = 0) -> sq_awaddr = 0x20000; CDW0 = 0x00000001; CDW10 = 5; PRP1 = 0; doorbell 0x1008 data 1.
- READ issued after 3 prior commands -> opcode 02h, cid = 3, sq_awaddr = 0x200C0, PRP1 = 0x3000, SQ doorbell data 4.
- CQE with P = 1, cid = 2, status = 0 -> cpl_valid with cpl_cid = 2; CQ doorbell at 0x100C with data 1; inflight decrements.
- CQE with stale P = 0 -> no cpl_valid; next read targets the same cq_araddr.
- Issue 15 commands at DEPTH = 16 without completions -> cmd_ready stays 0 on the 16th.
- Complete 16 entries -> cq_head wraps to 0, phase = 0; an entry with P = 0 is then accepted.
- Assert rst in SQ_AW_W -> all valids 0 the next cycle; pointers 0; phase 1.
- With DSTRD = 2, QID = 3 -> SQ doorbell at 0x1060, CQ doorbell at 0x1070.
